line_uart_sender: RTL and testbench

Consumes a fixed-width, zero-padded text line plus a send strobe from the control logic, and transmits the line's printable bytes over the board's UART TX pin as 8N1 frames. Sits directly downstream of the key/console control logic, in place of a separate writer and byte UART. Leading and embedded 0x00 padding bytes are dropped, so a right-justified string constant transmits only its characters.

---
 rtl/line_uart_sender.sv | 168 ++++++++++++++++
 tb/tb_line_uart_sender.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/line_uart_sender.sv
// Transmits the non-zero bytes of a captured text line as 8N1 UART frames, first byte from the
// top of the line. Zero padding bytes are skipped at one clock each.
module line_uart_sender #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned LINE_BYTES = 80
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LINE_BYTES*8-1:0] line,
  input  logic                    send,
  output logic                    uart_tx,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW  = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int unsigned LineW = LINE_BYTES * 8;

  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxTop   = IdxW'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StStart,
    StData,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [LineW-1:0] line_q, line_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0]  baud_q, baud_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             send_q;

  logic       trigger;
  logic       bit_end;
  logic [7:0] head_byte;

  // The shadow line is shifted left as bytes are consumed, so the current byte is always on top.
  assign head_byte = line_q[LineW-1 -: 8];
  assign bit_end   = (baud_q == BaudLast);
  assign trigger   = send & ~send_q;

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (trigger) begin
          line_d  = line;
          idx_d   = IdxTop;
          busy_d  = 1'b1;
          state_d = StScan;
        end
      end

      StScan: begin
        if (head_byte == 8'h00) begin
          if (idx_q != '0) begin
            idx_d  = idx_q - 1'b1;
            line_d = line_q << 8;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          shift_d   = head_byte;
          bit_cnt_d = '0;
          baud_d    = '0;
          tx_d      = 1'b0;
          state_d   = StStart;
        end
      end

      StStart: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end

      StData: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end

      StStop: begin
        baud_d = bit_end ? '0 : baud_q + 1'b1;
        if (bit_end) begin
          if (idx_q != '0) begin
            idx_d   = idx_q - 1'b1;
            line_d  = line_q << 8;
            state_d = StScan;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      line_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      baud_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      send_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      send_q    <= send;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_line_uart_sender.sv
// Bench for line_uart_sender: per-cycle uart_tx/busy/done compared against a trace built from
// the line's bytes (one scan cycle per byte, ten bit periods per non-zero byte, then done).
module tb_line_uart_sender;

  localparam int LW        = 640;
  localparam int MaxCycles = 1 << 30;

  logic          clk;
  logic          rst_n;
  logic [LW-1:0] line0, line1;
  logic          send0, send1;
  logic          tx0, busy0, done0;
  logic          tx1, busy1, done1;

  int vectors = 0;
  int errors  = 0;

  logic [2:0] exp_q[$];  // {uart_tx, busy, done} per cycle after the trigger edge

  line_uart_sender #(
    .CLK_FREQ  (1000),
    .BAUD      (100),
    .LINE_BYTES(80)
  ) u_dut_fast (
    .clk    (clk),
    .rst_n  (rst_n),
    .line   (line0),
    .send   (send0),
    .uart_tx(tx0),
    .busy   (busy0),
    .done   (done0)
  );

  line_uart_sender #(
    .LINE_BYTES(80)
  ) u_dut_default (
    .clk    (clk),
    .rst_n  (rst_n),
    .line   (line1),
    .send   (send1),
    .uart_tx(tx1),
    .busy   (busy1),
    .done   (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_send(input int which, input logic v);
    if (which == 0) send0 = v;
    else            send1 = v;
  endtask

  task automatic set_line(input int which, input logic [LW-1:0] v);
    if (which == 0) line0 = v;
    else            line1 = v;
  endtask

  task automatic build_exp(input logic [LW-1:0] ln, input int cpb, input int tail);
    exp_q.delete();
    for (int i = 79; i >= 0; i--) begin
      logic [7:0] b;
      b = ln[i*8 +: 8];
      exp_q.push_back(3'b110);
      if (b != 8'h00) begin
        for (int c = 0; c < cpb; c++) exp_q.push_back(3'b010);
        for (int j = 0; j < 8; j++)
          for (int c = 0; c < cpb; c++) exp_q.push_back({b[j], 2'b10});
        for (int c = 0; c < cpb; c++) exp_q.push_back(3'b110);
      end
    end
    exp_q.push_back(3'b101);
    for (int t = 0; t < tail; t++) exp_q.push_back(3'b100);
  endtask

  // Triggers a line and compares every following cycle; stops comparing after the first miss.
  task automatic check_line(input int which, input logic [LW-1:0] ln, input int cpb,
                            input int tail, input int pulse_at, input int hold_at,
                            input int stop_at);
    logic [2:0] obs;
    bit         ok;
    build_exp(ln, cpb, tail);
    @(negedge clk);
    set_send(which, 1'b0);
    set_line(which, ln);
    @(negedge clk);
    set_send(which, 1'b1);
    ok = 1'b1;
    for (int k = 0; k < exp_q.size() && k < stop_at; k++) begin
      @(negedge clk);
      obs = (which == 0) ? {tx0, busy0, done0} : {tx1, busy1, done1};
      if (ok) begin
        vectors++;
        assert (obs === exp_q[k]) else begin
          errors++;
          ok = 1'b0;
          $error("FAIL trace dut%0d cycle %0d: tx/busy/done observed %b expected %b",
                 which, k, obs, exp_q[k]);
        end
      end
      if (k == 0) begin
        set_send(which, 1'b0);
        set_line(which, {20{$urandom}});
      end
      if (k == pulse_at)     set_send(which, 1'b1);
      if (k == pulse_at + 1) set_send(which, 1'b0);
      if (k == hold_at)      set_send(which, 1'b1);
    end
  endtask

  task automatic check_idle(input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      vectors++;
      assert ({tx0, busy0, done0} === 3'b100) else begin
        errors++;
        $error("FAIL %s cycle %0d: tx/busy/done observed %b expected 100", tag, k,
               {tx0, busy0, done0});
        break;
      end
    end
  endtask

  initial begin
    logic [LW-1:0] ln;
    logic [LW-1:0] hi;
    rst_n = 1'b0;
    send0 = 1'b0;
    send1 = 1'b0;
    line0 = '0;
    line1 = '0;
    repeat (3) @(negedge clk);
    vectors++;
    assert ({tx0, busy0, done0} === 3'b100) else begin
      errors++;
      $error("FAIL reset dut0: tx/busy/done observed %b expected 100", {tx0, busy0, done0});
    end
    vectors++;
    assert ({tx1, busy1, done1} === 3'b100) else begin
      errors++;
      $error("FAIL reset dut1: tx/busy/done observed %b expected 100", {tx1, busy1, done1});
    end
    rst_n = 1'b1;

    hi = '0;
    hi[15:0] = "Hi";

    // "Hi": two frames, one done
    check_line(0, hi, 10, 5, -1, -1, MaxCycles);

    // all-zero line: scan only
    check_line(0, '0, 10, 5, -1, -1, MaxCycles);

    // 14-byte string with control characters
    ln = '0;
    ln[111:0] = "Hello Rosie!\n\r";
    check_line(0, ln, 10, 5, -1, -1, MaxCycles);

    // edge while busy is dropped; held-high send retriggers nothing
    check_line(0, hi, 10, 5000, 150, 200, MaxCycles);
    check_line(0, hi, 10, 5, -1, -1, MaxCycles);

    // reset mid-frame, then a clean resend
    check_line(0, hi, 10, 0, -1, -1, 150);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    assert ({tx0, busy0} === 2'b10) else begin
      errors++;
      $error("FAIL async_reset: tx/busy observed %b expected 10", {tx0, busy0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(300, "post_reset_idle");
    check_line(0, hi, 10, 5, -1, -1, MaxCycles);

    // random sparse lines
    for (int r = 0; r < 5; r++) begin
      ln = '0;
      for (int i = 0; i < 80; i++)
        if ($urandom_range(0, 7) == 0) ln[i*8 +: 8] = 8'($urandom_range(1, 255));
      if (r == 0) ln[LW-1 -: 8] = 8'($urandom_range(1, 255));
      check_line(0, ln, 10, 3, -1, -1, MaxCycles);
    end

    // fully populated line, no skipped bytes
    for (int i = 0; i < 80; i++) ln[i*8 +: 8] = 8'($urandom_range(1, 255));
    check_line(0, ln, 10, 3, -1, -1, MaxCycles);

    // default parameters: 434-clock bits
    ln = '0;
    ln[7:0] = "A";
    check_line(1, ln, 434, 5, -1, -1, MaxCycles);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
